sbit_frame_aligner: RTL and testbench

Parametrised, fully synchronous successor to the per-VFAT S-bit frame alignment stage. It takes already-sampled S-bit and start-of-frame (SOF) bit words from every VFAT in the `clock` domain and finds each VFAT's SOF bit offset. It then runs a per-VFAT lock/unlock state machine and emits bit-aligned S-bit frames together with lock status, error pulses and saturating error counters. It sits between the oversampler array and the cluster packer, and replaces the fixed 24-VFAT, single-mode aligner with one generalised in VFAT count, pin count, frame length and lock hysteresis.

---
 rtl/sbit_frame_aligner_if.sv | 34 +++
 rtl/sbit_frame_aligner.sv | 132 +++++++++++++
 tb/tb_sbit_frame_aligner.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sbit_frame_aligner_if.sv
// Bundles the per-VFAT SOF/S-bit sample words and the aligned frame, lock and error outputs.
// Latency: none, wires only.
// Backpressure: none, one word set per clock in each direction.
// Ports: cnt_reset, sbit_mask, sof_bits, sbits_in (towards the aligner);
//        sbits_out, locked, offset, alignment_err, err_cnt (from the aligner).
// master = the source side (oversamplers/control); slave = the aligner.
interface sbit_frame_aligner_if #(
    parameter int NUM_VFATS = 24,
    parameter int PINS      = 8,
    parameter int FRAME_LEN = 8,
    parameter int ERRCNT_W  = 12
);
    localparam int OFS_W = $clog2(FRAME_LEN);

    logic                                cnt_reset;
    logic [NUM_VFATS-1:0]                sbit_mask;
    logic [NUM_VFATS*FRAME_LEN-1:0]      sof_bits;
    logic [NUM_VFATS*PINS*FRAME_LEN-1:0] sbits_in;
    logic [NUM_VFATS*PINS*FRAME_LEN-1:0] sbits_out;
    logic [NUM_VFATS-1:0]                locked;
    logic [NUM_VFATS*OFS_W-1:0]          offset;
    logic [NUM_VFATS-1:0]                alignment_err;
    logic [NUM_VFATS*ERRCNT_W-1:0]       err_cnt;

    modport master (
        output cnt_reset, sbit_mask, sof_bits, sbits_in,
        input  sbits_out, locked, offset, alignment_err, err_cnt
    );

    modport slave (
        input  cnt_reset, sbit_mask, sof_bits, sbits_in,
        output sbits_out, locked, offset, alignment_err, err_cnt
    );
endinterface

// File: rtl/sbit_frame_aligner.sv
// Finds each VFAT's SOF bit offset, runs a SEARCH/VERIFY/LOCKED machine and emits bit-aligned S-bit frames.
// Latency: lock/offset/error effects 1 clock after the SOF word; aligned data 2 clocks after the input word.
// Backpressure: none, one frame accepted and one produced every clock.
// Ports: clock; reset (synchronous, active-high); bus (slave modport) carrying cnt_reset, sbit_mask,
//        sof_bits, sbits_in in and sbits_out, locked, offset, alignment_err, err_cnt out.
module sbit_frame_aligner #(
    parameter int NUM_VFATS   = 24,
    parameter int PINS        = 8,
    parameter int FRAME_LEN   = 8,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERRCNT_W    = 12
) (
    input  logic                clock,
    input  logic                reset,
    sbit_frame_aligner_if.slave bus
);
    localparam int OFS_W = $clog2(FRAME_LEN);
    localparam int VW    = PINS * FRAME_LEN;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    for (genvar v = 0; v < NUM_VFATS; v++) begin : g_vfat
        logic [FRAME_LEN-1:0]   sof;
        logic [VW-1:0]          cur;
        logic                   mask;
        state_t                 state;
        logic [7:0]             match_cnt;
        logic [7:0]             miss_cnt;
        logic [OFS_W-1:0]       off_q;
        logic [OFS_W-1:0]       sof_pos;
        logic                   sof_ok;
        logic                   err_hit;
        logic                   err_q;
        logic [ERRCNT_W-1:0]    err_cnt_q;
        logic [FRAME_LEN-1:0]   expect_sof;
        logic [VW-1:0]          prev_q;
        logic [VW-1:0]          out_q;
        logic [VW-1:0]          aligned;
        logic [2*FRAME_LEN-1:0] cat;

        assign sof  = bus.sof_bits[v*FRAME_LEN +: FRAME_LEN];
        assign cur  = bus.sbits_in[v*VW +: VW];
        assign mask = bus.sbit_mask[v];

        always_comb begin
            // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
            sof_ok     = (sof != '0) && ((sof & (sof - FRAME_LEN'(1))) == '0);
            sof_pos    = '0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                if (sof[i]) sof_pos = OFS_W'(i);
            end
            expect_sof = FRAME_LEN'(1) << off_q;
            // Any word other than the exact expected one-hot counts as a miss while locked.
            err_hit    = !mask && (state == LOCKED) && (sof != expect_sof);
            cat        = '0;
            aligned    = '0;
            // Frame starts at the SOF bit of the previous word and borrows the early bits of the current one.
            for (int p = 0; p < PINS; p++) begin
                cat = {cur[p*FRAME_LEN +: FRAME_LEN], prev_q[p*FRAME_LEN +: FRAME_LEN]} >> off_q;
                aligned[p*FRAME_LEN +: FRAME_LEN] = cat[FRAME_LEN-1:0];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state     <= SEARCH;
                match_cnt <= '0;
                miss_cnt  <= '0;
                off_q     <= '0;
                err_q     <= 1'b0;
                err_cnt_q <= '0;
                prev_q    <= '0;
                out_q     <= '0;
            end else begin
                prev_q <= cur;
                err_q  <= err_hit;
                out_q  <= (state == LOCKED && !mask) ? aligned : '0;

                if (mask) begin
                    state     <= SEARCH;
                    match_cnt <= '0;
                    miss_cnt  <= '0;
                end else begin
                    case (state)
                        SEARCH: begin
                            if (sof_ok) begin
                                off_q     <= sof_pos;
                                match_cnt <= 8'd1;
                                state     <= (LOCK_CNT == 1) ? LOCKED : VERIFY;
                            end
                        end
                        VERIFY: begin
                            if (sof_ok && sof_pos == off_q) begin
                                match_cnt <= match_cnt + 8'd1;
                                if (match_cnt + 8'd1 == 8'(LOCK_CNT)) state <= LOCKED;
                            end else begin
                                // Offset is recaptured from SEARCH on a later word, not from this one.
                                state     <= SEARCH;
                                match_cnt <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!err_hit) begin
                                miss_cnt <= '0;
                            end else if (miss_cnt + 8'd1 == 8'(UNLOCK_ERRS)) begin
                                state    <= SEARCH;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 8'd1;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                end

                // Clear wins over a same-cycle increment; counter saturates at all-ones.
                if (bus.cnt_reset) begin
                    err_cnt_q <= '0;
                end else if (err_hit && err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
                end
            end
        end

        assign bus.sbits_out[v*VW +: VW]             = out_q;
        assign bus.locked[v]                         = (state == LOCKED);
        assign bus.offset[v*OFS_W +: OFS_W]          = off_q;
        assign bus.alignment_err[v]                  = err_q;
        assign bus.err_cnt[v*ERRCNT_W +: ERRCNT_W]   = err_cnt_q;
    end
endmodule

// File: tb/tb_sbit_frame_aligner.sv
// Directed bench for sbit_frame_aligner: an SDR build (24 VFATs) and a DDR build (4 VFATs, 3-bit counters, LOCK_CNT=1).
// Latency: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none.
module tb_sbit_frame_aligner;
    logic clock = 1'b0;
    logic rst_sdr;
    logic rst_ddr;
    always #5 clock = ~clock;

    sbit_frame_aligner_if #(.NUM_VFATS(24), .PINS(8), .FRAME_LEN(8),  .ERRCNT_W(12)) if_sdr ();
    sbit_frame_aligner_if #(.NUM_VFATS(4),  .PINS(2), .FRAME_LEN(16), .ERRCNT_W(3))  if_ddr ();

    sbit_frame_aligner #(
        .NUM_VFATS(24), .PINS(8), .FRAME_LEN(8), .LOCK_CNT(16), .UNLOCK_ERRS(4), .ERRCNT_W(12)
    ) dut_sdr (
        .clock (clock),
        .reset (rst_sdr),
        .bus   (if_sdr)
    );

    sbit_frame_aligner #(
        .NUM_VFATS(4), .PINS(2), .FRAME_LEN(16), .LOCK_CNT(1), .UNLOCK_ERRS(16), .ERRCNT_W(3)
    ) dut_ddr (
        .clock (clock),
        .reset (rst_ddr),
        .bus   (if_ddr)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_sdr = 1'b1;
        rst_ddr = 1'b1;
        if_sdr.cnt_reset = 1'b0;
        if_sdr.sbit_mask = '0;
        if_sdr.sof_bits  = '0;
        for (int i = 0; i < 24*8; i++) if_sdr.sbits_in[i*8 +: 8] = 8'h2D;
        if_ddr.cnt_reset = 1'b0;
        if_ddr.sbit_mask = '0;
        if_ddr.sof_bits  = {4{16'h8000}};   // would lock at once if reset were ignored
        if_ddr.sbits_in  = '0;
        tick();
        tick();
        vectors++; if (if_sdr.locked !== 24'h0) begin errors++; $display("FAIL reset_sdr_locked: got %h expected 0", if_sdr.locked); end
        vectors++; if (if_sdr.sbits_out !== '0) begin errors++; $display("FAIL reset_sdr_sbits_out: got nonzero expected 0"); end
        vectors++; if (if_sdr.offset !== '0) begin errors++; $display("FAIL reset_sdr_offset: got %h expected 0", if_sdr.offset); end
        vectors++; if (if_sdr.alignment_err !== 24'h0) begin errors++; $display("FAIL reset_sdr_err: got %h expected 0", if_sdr.alignment_err); end
        vectors++; if (if_sdr.err_cnt !== '0) begin errors++; $display("FAIL reset_sdr_err_cnt: got %h expected 0", if_sdr.err_cnt); end
        vectors++; if (if_ddr.locked !== 4'h0) begin errors++; $display("FAIL reset_ddr_locked: got %h expected 0", if_ddr.locked); end
        vectors++; if (if_ddr.offset !== 16'h0) begin errors++; $display("FAIL reset_ddr_offset: got %h expected 0", if_ddr.offset); end
        rst_sdr = 1'b0;
        rst_ddr = 1'b0;
        if_ddr.sof_bits = '0;
    endtask

    // All VFATs except 1 see SOF at bit 3; pin data 0x2D aligns to 0xA5.
    task automatic test_lock_sdr();
        for (int v = 0; v < 24; v++) if_sdr.sof_bits[v*8 +: 8] = (v == 1) ? 8'h00 : 8'h08;
        for (int n = 1; n <= 17; n++) begin
            tick();
            vectors++; if (if_sdr.alignment_err !== 24'h0) begin errors++; $display("FAIL lock_no_err n=%0d: got %h expected 0", n, if_sdr.alignment_err); end
            if (n == 1) begin
                vectors++; if (if_sdr.offset[2:0] !== 3'd3) begin errors++; $display("FAIL lock_offset: got %0d expected 3", if_sdr.offset[2:0]); end
                vectors++; if (if_sdr.locked !== 24'h0) begin errors++; $display("FAIL lock_early n=1: got %h expected 0", if_sdr.locked); end
            end
            if (n == 15) begin
                vectors++; if (if_sdr.locked !== 24'h0) begin errors++; $display("FAIL lock_early n=15: got %h expected 0", if_sdr.locked); end
            end
            if (n == 16) begin
                vectors++; if (if_sdr.locked !== 24'hFFFFFD) begin errors++; $display("FAIL lock_rise: got %h expected fffffd", if_sdr.locked); end
                vectors++; if (if_sdr.sbits_out[7:0] !== 8'h00) begin errors++; $display("FAIL lock_first_out: got %h expected 00", if_sdr.sbits_out[7:0]); end
            end
            if (n == 17) begin
                vectors++; if (if_sdr.sbits_out[7:0] !== 8'hA5) begin errors++; $display("FAIL lock_aligned: got %h expected a5", if_sdr.sbits_out[7:0]); end
            end
        end
    endtask

    // Varying words on VFAT 0 pin 0: out = {next[2:0], word[7:3]}, two cycles after word.
    task automatic test_back_to_back();
        logic [7:0] din [4];
        logic [7:0] exp [4];
        din = '{8'h00, 8'hFF, 8'h2D, 8'h2D};
        exp = '{8'h05, 8'hE0, 8'hBF, 8'hA5};
        for (int i = 0; i < 4; i++) begin
            if_sdr.sbits_in[7:0] = din[i];
            tick();
            vectors++; if (if_sdr.sbits_out[7:0] !== exp[i]) begin errors++; $display("FAIL b2b_out[%0d]: got %h expected %h", i, if_sdr.sbits_out[7:0], exp[i]); end
        end
    endtask

    // VFAT 1: 10 matches, one empty word, then restart.
    task automatic test_verify_abort();
        for (int c = 0; c <= 26; c++) begin
            if_sdr.sof_bits[15:8] = (c == 10) ? 8'h00 : 8'h04;
            tick();
            vectors++; if (if_sdr.alignment_err[1] !== 1'b0) begin errors++; $display("FAIL abort_no_err n=%0d: got 1 expected 0", c+1); end
            if (c + 1 == 16 || c + 1 == 26) begin
                vectors++; if (if_sdr.locked[1] !== 1'b0) begin errors++; $display("FAIL abort_locked n=%0d: got 1 expected 0", c+1); end
            end
            if (c + 1 == 27) begin
                vectors++; if (if_sdr.locked[1] !== 1'b1) begin errors++; $display("FAIL abort_relock: got 0 expected 1"); end
                vectors++; if (if_sdr.offset[5:3] !== 3'd2) begin errors++; $display("FAIL abort_offset: got %0d expected 2", if_sdr.offset[5:3]); end
            end
        end
    endtask

    task automatic test_unlock();
        logic [7:0]  sofs [9];
        logic        e_err [9];
        logic [11:0] e_cnt [9];
        logic        e_lck [9];
        sofs  = '{8'h00, 8'h18, 8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
        e_err = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_cnt = '{12'd1, 12'd2, 12'd3, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd7};
        e_lck = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            if_sdr.sof_bits[7:0] = sofs[k];
            tick();
            vectors++; if (if_sdr.alignment_err[0] !== e_err[k]) begin errors++; $display("FAIL unlock_err k=%0d: got %b expected %b", k, if_sdr.alignment_err[0], e_err[k]); end
            vectors++; if (if_sdr.err_cnt[11:0] !== e_cnt[k]) begin errors++; $display("FAIL unlock_cnt k=%0d: got %0d expected %0d", k, if_sdr.err_cnt[11:0], e_cnt[k]); end
            vectors++; if (if_sdr.locked[0] !== e_lck[k]) begin errors++; $display("FAIL unlock_locked k=%0d: got %b expected %b", k, if_sdr.locked[0], e_lck[k]); end
            if (k == 7) begin
                vectors++; if (if_sdr.sbits_out[7:0] !== 8'hA5) begin errors++; $display("FAIL unlock_last_out: got %h expected a5", if_sdr.sbits_out[7:0]); end
            end
            if (k == 8) begin
                vectors++; if (if_sdr.sbits_out[63:0] !== 64'h0) begin errors++; $display("FAIL unlock_out_zero: got %h expected 0", if_sdr.sbits_out[63:0]); end
            end
        end
    endtask

    task automatic test_mask();
        if_sdr.sbit_mask[5] = 1'b1;
        if_sdr.sof_bits[47:40] = 8'h00;
        tick();
        vectors++; if (if_sdr.locked[5] !== 1'b0) begin errors++; $display("FAIL mask_locked: got 1 expected 0"); end
        vectors++; if (if_sdr.sbits_out[5*64 +: 64] !== 64'h0) begin errors++; $display("FAIL mask_out: got %h expected 0", if_sdr.sbits_out[5*64 +: 64]); end
        vectors++; if (if_sdr.alignment_err[5] !== 1'b0) begin errors++; $display("FAIL mask_err: got 1 expected 0"); end
        vectors++; if (if_sdr.locked[4] !== 1'b1) begin errors++; $display("FAIL mask_neighbour_locked: got 0 expected 1"); end
        vectors++; if (if_sdr.sbits_out[4*64 +: 8] !== 8'hA5) begin errors++; $display("FAIL mask_neighbour_out: got %h expected a5", if_sdr.sbits_out[4*64 +: 8]); end
        tick();
        vectors++; if (if_sdr.err_cnt[5*12 +: 12] !== 12'd0) begin errors++; $display("FAIL mask_err_cnt: got %0d expected 0", if_sdr.err_cnt[5*12 +: 12]); end
        if_sdr.sbit_mask[5] = 1'b0;
        if_sdr.sof_bits[47:40] = 8'h08;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 15) begin
                vectors++; if (if_sdr.locked[5] !== 1'b0) begin errors++; $display("FAIL unmask_early: got 1 expected 0"); end
            end
            if (n == 16) begin
                vectors++; if (if_sdr.locked[5] !== 1'b1) begin errors++; $display("FAIL unmask_relock: got 0 expected 1"); end
            end
        end
    endtask

    // DDR, LOCK_CNT=1: out = {cur[14:0], prev[15]}.
    task automatic test_ddr_align();
        if_ddr.sof_bits[15:0] = 16'h8000;
        if_ddr.sbits_in[15:0] = 16'h8001;
        tick();
        vectors++; if (if_ddr.offset[3:0] !== 4'd15) begin errors++; $display("FAIL ddr_offset: got %0d expected 15", if_ddr.offset[3:0]); end
        vectors++; if (if_ddr.locked[0] !== 1'b1) begin errors++; $display("FAIL ddr_direct_lock: got 0 expected 1"); end
        vectors++; if (if_ddr.sbits_out[15:0] !== 16'h0) begin errors++; $display("FAIL ddr_first_out: got %h expected 0", if_ddr.sbits_out[15:0]); end
        if_ddr.sbits_in[15:0] = 16'h0003;
        tick();
        vectors++; if (if_ddr.sbits_out[15:0] !== 16'h0007) begin errors++; $display("FAIL ddr_out0: got %h expected 0007", if_ddr.sbits_out[15:0]); end
        if_ddr.sbits_in[15:0] = 16'hFFFF;
        tick();
        vectors++; if (if_ddr.sbits_out[15:0] !== 16'hFFFE) begin errors++; $display("FAIL ddr_out1: got %h expected fffe", if_ddr.sbits_out[15:0]); end
        tick();
        vectors++; if (if_ddr.sbits_out[15:0] !== 16'hFFFF) begin errors++; $display("FAIL ddr_out2: got %h expected ffff", if_ddr.sbits_out[15:0]); end
    endtask

    task automatic test_counters();
        logic [2:0] exp;
        if_ddr.sof_bits[15:0] = 16'h0000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp = (k > 7) ? 3'd7 : 3'(k);
            vectors++; if (if_ddr.err_cnt[2:0] !== exp) begin errors++; $display("FAIL cnt_sat k=%0d: got %0d expected %0d", k, if_ddr.err_cnt[2:0], exp); end
        end
        vectors++; if (if_ddr.locked[0] !== 1'b1) begin errors++; $display("FAIL cnt_still_locked: got 0 expected 1"); end
        if_ddr.cnt_reset = 1'b1;
        tick();
        vectors++; if (if_ddr.alignment_err[0] !== 1'b1) begin errors++; $display("FAIL cnt_clr_err_pulse: got 0 expected 1"); end
        vectors++; if (if_ddr.err_cnt[2:0] !== 3'd0) begin errors++; $display("FAIL cnt_clr_priority: got %0d expected 0", if_ddr.err_cnt[2:0]); end
        if_ddr.cnt_reset = 1'b0;
        if_ddr.sof_bits[15:0] = 16'h8000;
        tick();
        vectors++; if (if_ddr.err_cnt[2:0] !== 3'd0) begin errors++; $display("FAIL cnt_after_clr: got %0d expected 0", if_ddr.err_cnt[2:0]); end
        vectors++; if (if_ddr.alignment_err[0] !== 1'b0) begin errors++; $display("FAIL cnt_good_no_err: got 1 expected 0"); end
    endtask

    task automatic test_ddr_reset();
        if_ddr.sof_bits[15:0] = 16'h0000;
        tick();
        vectors++; if (if_ddr.err_cnt[2:0] !== 3'd1) begin errors++; $display("FAIL rst_pre_cnt: got %0d expected 1", if_ddr.err_cnt[2:0]); end
        rst_ddr = 1'b1;
        if_ddr.sof_bits[15:0] = 16'h8000;
        tick();
        vectors++; if (if_ddr.locked !== 4'h0) begin errors++; $display("FAIL rst_locked: got %h expected 0", if_ddr.locked); end
        vectors++; if (if_ddr.sbits_out !== '0) begin errors++; $display("FAIL rst_out: got %h expected 0", if_ddr.sbits_out); end
        vectors++; if (if_ddr.offset !== 16'h0) begin errors++; $display("FAIL rst_offset: got %h expected 0", if_ddr.offset); end
        vectors++; if (if_ddr.err_cnt !== 12'h0) begin errors++; $display("FAIL rst_err_cnt: got %h expected 0", if_ddr.err_cnt); end
        vectors++; if (if_ddr.alignment_err !== 4'h0) begin errors++; $display("FAIL rst_err: got %h expected 0", if_ddr.alignment_err); end
        rst_ddr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_sdr();
        test_back_to_back();
        test_verify_abort();
        test_unlock();
        test_mask();
        test_ddr_align();
        test_counters();
        test_ddr_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
